// File: rtl/dcm_rst_seq.sv
// rtl/dcm_rst_seq.sv - DCM_SP reset pulse, lock acquisition and system reset sequencer
//
// Purpose:
//   Pulses the DCM reset, waits for a synchronised LOCKED with timeout and bounded
//   retries, holds the system in reset until lock has been stable, and re-sequences
//   the DCM whenever lock is lost. Clocked by the free-running input clock only.
//
// Ports:
//   CLK_IN        in   free-running clock (IBUFG output)
//   RST_IN        in   synchronous active-high reset
//   LOCKED_IN     in   DCM LOCKED (asynchronous to CLK_IN, synchronised here)
//   STATUS_IN     in   DCM STATUS bus, observed only with DCM_STATUS_MON_EN
//   DCM_RST_OUT   out  reset to the DCM RST pin
//   SYS_RST_OUT   out  reset to downstream logic
//   READY_OUT     out  clocks valid, system running
//   FAIL_OUT      out  sticky lock failure, cleared only by RST_IN
//   RETRY_CNT_OUT out  retries used in the current acquisition
//
// Optional build macro:
//   DCM_STATUS_MON_EN - STATUS_IN[1] (CLKIN stopped) and STATUS_IN[2] (CLKFX stopped)
//   count as loss of lock while in STABLE and RUN.

module dcm_rst_seq #(
  parameter int RST_CYCLES    = 3,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       LOCKED_IN,
  input  logic [7:0] STATUS_IN,
  output logic       DCM_RST_OUT,
  output logic       SYS_RST_OUT,
  output logic       READY_OUT,
  output logic       FAIL_OUT,
  output logic [3:0] RETRY_CNT_OUT
);

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_t      state;
  state_t      state_n;
  logic [15:0] count;
  logic [15:0] count_n;
  logic [3:0]  retry;
  logic [3:0]  retry_n;
  logic        lock_m;
  logic        lock_s;
  logic        lost;

  // LOCKED_IN comes from the DCM and is asynchronous to CLK_IN.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= LOCKED_IN;
      lock_s <= lock_m;
    end
  end

`ifdef DCM_STATUS_MON_EN
  logic [1:0] stop_m;
  logic [1:0] stop_s;
  logic       status_unused;

  assign status_unused = ^{STATUS_IN[7:3], STATUS_IN[0]};

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      stop_m <= 2'b00;
      stop_s <= 2'b00;
    end else begin
      stop_m <= STATUS_IN[2:1];
      stop_s <= stop_m;
    end
  end

  // A stopped input or synthesised clock is as bad as a dropped LOCKED.
  assign lost = !lock_s || (stop_s != 2'b00);
`else
  logic status_unused;

  assign status_unused = ^STATUS_IN;
  assign lost          = !lock_s;
`endif

  always_comb begin
    state_n = state;
    retry_n = retry;
    case (state)
      RESET_DCM: begin
        if (count == RST_LAST) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_n = STABLE;
        end else if (count == TIMEOUT_LAST) begin
          if (retry == RETRY_MAX) begin
            state_n = FAIL;
          end else begin
            retry_n = retry + 4'd1;
            state_n = RESET_DCM;
          end
        end
      end
      STABLE: begin
        if (lost) begin
          state_n = WAIT_LOCK;
        end else if (count == STABLE_LAST) begin
          state_n = RUN;
          retry_n = 4'd0;
        end
      end
      RUN: begin
        if (lost) state_n = RESET_DCM;
      end
      FAIL: begin
        state_n = FAIL;
      end
      default: begin
        state_n = RESET_DCM;
      end
    endcase
    // One counter serves every state; any state change restarts it.
    count_n = (state_n != state) ? 16'd0 : count + 16'd1;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state       <= RESET_DCM;
      count       <= 16'd0;
      retry       <= 4'd0;
      DCM_RST_OUT <= 1'b1;
      SYS_RST_OUT <= 1'b1;
      READY_OUT   <= 1'b0;
      FAIL_OUT    <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      retry       <= retry_n;
      DCM_RST_OUT <= (state_n == RESET_DCM) || (state_n == FAIL);
      SYS_RST_OUT <= (state_n != RUN);
      READY_OUT   <= (state_n == RUN);
      FAIL_OUT    <= (state_n == FAIL);
    end
  end

  assign RETRY_CNT_OUT = retry;

endmodule

// File: tb/tb_dcm_rst_seq.sv
// tb/tb_dcm_rst_seq.sv - self-checking bench for dcm_rst_seq with a phase/countdown reference model

module tb_dcm_rst_seq;

  localparam int RC = 3;
  localparam int TO = 16;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_DEAD   = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic [7:0] status = 8'h00;
  logic       dcm_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  wire  [7:0] obs = {dcm_rst, sys_rst, ready, fail, retry_cnt};

  int checks = 0;
  int errors = 0;

  dcm_rst_seq #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(SC),
    .MAX_RETRY    (MR)
  ) dut (
    .CLK_IN       (clk),
    .RST_IN       (rst),
    .LOCKED_IN    (locked),
    .STATUS_IN    (status),
    .DCM_RST_OUT  (dcm_rst),
    .SYS_RST_OUT  (sys_rst),
    .READY_OUT    (ready),
    .FAIL_OUT     (fail),
    .RETRY_CNT_OUT(retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: current phase, cycles remaining in it, retries spent.
  int ph    = PH_PULSE;
  int rem   = RC;
  int tries = 0;
  bit lock_q[$] = '{1'b0, 1'b0};
`ifdef DCM_STATUS_MON_EN
  bit [1:0] stop_q[$] = '{2'b00, 2'b00};
`endif

  task automatic model_edge();
    bit seen;
    bit bad;
    if (rst) begin
      ph     = PH_PULSE;
      rem    = RC;
      tries  = 0;
      lock_q = '{1'b0, 1'b0};
`ifdef DCM_STATUS_MON_EN
      stop_q = '{2'b00, 2'b00};
`endif
    end else begin
      seen = lock_q.pop_front();
      lock_q.push_back(locked);
      bad = !seen;
`ifdef DCM_STATUS_MON_EN
      if (stop_q.pop_front() != 2'b00) bad = 1'b1;
      stop_q.push_back(status[2:1]);
`endif
      case (ph)
        PH_PULSE: begin
          rem--;
          if (rem == 0) begin ph = PH_WAIT; rem = TO; end
        end
        PH_WAIT: begin
          if (seen) begin
            ph = PH_SETTLE; rem = SC;
          end else begin
            rem--;
            if (rem == 0) begin
              if (tries == MR) ph = PH_DEAD;
              else begin tries++; ph = PH_PULSE; rem = RC; end
            end
          end
        end
        PH_SETTLE: begin
          if (bad) begin
            ph = PH_WAIT; rem = TO;
          end else begin
            rem--;
            if (rem == 0) begin ph = PH_RUN; tries = 0; end
          end
        end
        PH_RUN: begin
          if (bad) begin ph = PH_PULSE; rem = RC; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] expected();
    logic d, s, r, f;
    d = (ph == PH_PULSE) || (ph == PH_DEAD);
    s = (ph != PH_RUN);
    r = (ph == PH_RUN);
    f = (ph == PH_DEAD);
    return {d, s, r, f, 4'(tries)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    repeat (3) tick();
    checks++;
    if (obs !== 8'hC0) begin errors++; $display("FAIL reset_values: got %h want %h", obs, 8'hC0); end
    checks++;
    if (obs !== expected()) begin errors++; $display("FAIL reset_model: got %h want %h", obs, expected()); end
  endtask

  task automatic test_lock_basic();
    int dcm_high;
    int edges;
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    tick(); tick();
    rst = 1'b0;
    dcm_high = (dcm_rst === 1'b1) ? 1 : 0;
    edges = 0;
    while (dcm_rst === 1'b1 && edges < 20) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL lock_basic_pulse: got %h want %h", obs, expected()); end
      if (dcm_rst === 1'b1) dcm_high++;
    end
    checks++;
    if (dcm_high != RC) begin errors++; $display("FAIL lock_basic_pulse_len: got %0d want %0d", dcm_high, RC); end
    repeat (5) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL lock_basic_wait: got %h want %h", obs, expected()); end
    end
    locked = 1'b1;
    edges = 0;
    while (ready !== 1'b1 && edges < 40) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL lock_basic_acq: got %h want %h", obs, expected()); end
    end
    checks++;
    if (edges - 1 != 2 + SC) begin errors++; $display("FAIL lock_basic_latency: got %0d want %0d", edges - 1, 2 + SC); end
    checks++;
    if (obs !== 8'h20) begin errors++; $display("FAIL lock_basic_run: got %h want %h", obs, 8'h20); end
  endtask

  task automatic test_fail();
    int edges;
    int rises;
    logic prev;
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    tick(); tick();
    rst = 1'b0;
    edges = 0; rises = 0; prev = dcm_rst;
    while (fail !== 1'b1 && edges < 200) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL fail_seq: got %h want %h", obs, expected()); end
      if (dcm_rst === 1'b1 && prev === 1'b0 && fail === 1'b0) rises++;
      prev = dcm_rst;
    end
    checks++;
    if (edges != 3 * (RC + TO)) begin errors++; $display("FAIL fail_time: got %0d want %0d", edges, 3 * (RC + TO)); end
    checks++;
    if (rises != MR) begin errors++; $display("FAIL fail_retry_pulses: got %0d want %0d", rises, MR); end
    checks++;
    if (obs !== {4'b1101, 4'(MR)}) begin errors++; $display("FAIL fail_outputs: got %h want %h", obs, {4'b1101, 4'(MR)}); end
    locked = 1'b1;
    repeat (20) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL fail_sticky: got %h want %h", obs, expected()); end
    end
    checks++;
    if (fail !== 1'b1 || sys_rst !== 1'b1) begin errors++; $display("FAIL fail_sticky_end: got %h want %h", obs, {4'b1101, 4'(MR)}); end
  endtask

  task automatic test_stable_drop();
    int edges;
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    tick(); tick();
    rst = 1'b0;
    edges = 0;
    while (dcm_rst === 1'b1 && edges < 20) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL stable_drop_pulse: got %h want %h", obs, expected()); end
    end
    locked = 1'b1;
    repeat (7) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL stable_drop_lock: got %h want %h", obs, expected()); end
    end
    locked = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL stable_drop_loss: got %h want %h", obs, expected()); end
    end
    checks++;
    if (obs !== 8'h40) begin errors++; $display("FAIL stable_drop_state: got %h want %h", obs, 8'h40); end
    locked = 1'b1;
    edges = 0;
    while (ready !== 1'b1 && edges < 40) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL stable_drop_relock: got %h want %h", obs, expected()); end
    end
    checks++;
    if (obs !== 8'h20) begin errors++; $display("FAIL stable_drop_ready: got %h want %h", obs, 8'h20); end
  endtask

  task automatic test_run_drop();
    int edges;
    int dcm_high;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    checks++;
    if (obs !== expected()) begin errors++; $display("FAIL run_drop_sample: got %h want %h", obs, expected()); end
    edges = 0;
    while (sys_rst !== 1'b1 && edges < 10) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL run_drop_react: got %h want %h", obs, expected()); end
    end
    checks++;
    if (edges != 2) begin errors++; $display("FAIL run_drop_latency: got %0d want %0d", edges, 2); end
    dcm_high = (dcm_rst === 1'b1) ? 1 : 0;
    edges = 0;
    while (dcm_rst === 1'b1 && edges < 20) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL run_drop_pulse: got %h want %h", obs, expected()); end
      if (dcm_rst === 1'b1) dcm_high++;
    end
    checks++;
    if (dcm_high != RC) begin errors++; $display("FAIL run_drop_pulse_len: got %0d want %0d", dcm_high, RC); end
    edges = 0;
    while (ready !== 1'b1 && edges < 40) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL run_drop_reacq: got %h want %h", obs, expected()); end
    end
    checks++;
    if (obs !== 8'h20) begin errors++; $display("FAIL run_drop_ready: got %h want %h", obs, 8'h20); end
  endtask

  task automatic test_mid_reset();
    int edges;
    int dcm_high;
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    tick(); tick();
    rst = 1'b0;
    edges = 0;
    while (!(retry_cnt === 4'd1 && dcm_rst === 1'b0) && edges < 100) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL mid_reset_run: got %h want %h", obs, expected()); end
    end
    repeat (3) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL mid_reset_wait: got %h want %h", obs, expected()); end
    end
    checks++;
    if (obs !== 8'h41) begin errors++; $display("FAIL mid_reset_pre: got %h want %h", obs, 8'h41); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== 8'hC0) begin errors++; $display("FAIL mid_reset_values: got %h want %h", obs, 8'hC0); end
    dcm_high = (dcm_rst === 1'b1) ? 1 : 0;
    edges = 0;
    while (dcm_rst === 1'b1 && edges < 20) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL mid_reset_pulse: got %h want %h", obs, expected()); end
      if (dcm_rst === 1'b1) dcm_high++;
    end
    checks++;
    if (dcm_high != RC) begin errors++; $display("FAIL mid_reset_pulse_len: got %0d want %0d", dcm_high, RC); end
  endtask

  task automatic test_status();
    int edges;
    int first_rise;
    rst = 1'b1; locked = 1'b1; status = 8'h00;
    tick(); tick();
    rst = 1'b0;
    edges = 0;
    while (ready !== 1'b1 && edges < 60) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL status_acq: got %h want %h", obs, expected()); end
    end
    status = 8'h04;
    first_rise = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL status_react: got %h want %h", obs, expected()); end
      if (sys_rst === 1'b1 && first_rise == 0) first_rise = i;
    end
`ifdef DCM_STATUS_MON_EN
    checks++;
    if (first_rise < 1 || first_rise > 3) begin errors++; $display("FAIL status_latency: got %0d want 1..3", first_rise); end
`else
    checks++;
    if (first_rise != 0 || obs !== 8'h20) begin errors++; $display("FAIL status_ignored: got %h rise %0d want %h", obs, first_rise, 8'h20); end
`endif
    status = 8'h00;
    edges = 0;
    while (ready !== 1'b1 && edges < 60) begin
      tick(); edges++;
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL status_recover: got %h want %h", obs, expected()); end
    end
  endtask

  task automatic test_random();
    int hold;
    rst = 1'b1; locked = 1'b0; status = 8'h00;
    tick();
    rst = 1'b0;
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        locked = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      status = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL random_cycle %0d: got %h want %h", i, obs, expected()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_fail();
    test_stable_drop();
    test_run_drop();
    test_mid_reset();
    test_status();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_rst_seq.md
Name: dcm_rst_seq

Overview:
Power-up and recovery sequencer for the DCM_SP clock manager.
- Pulses the DCM reset for a fixed length, then waits for LOCKED, with a timeout and a bounded retry count.
- Holds the system reset until lock has been stable for a set time.
- Re-sequences the DCM whenever lock is lost in operation.
- Runs on the free-running input clock (the IBUFG output), never on a DCM output clock.

Parameters:
RST_CYCLES, 3, cycles DCM_RST_OUT is held high per reset pulse (1..255)
LOCK_TIMEOUT, 1024, cycles to wait for synchronised lock before a retry (1..65535)
STABLE_CYCLES, 256, consecutive locked cycles required before releasing the system (1..65535)
MAX_RETRY, 3, number of retries allowed after the first attempt before FAIL (0..15)

Ports:
CLK_IN  in  1  free-running clock, IBUFG output
RST_IN  in  1  synchronous active-high reset
LOCKED_IN  in  1  DCM LOCKED
STATUS_IN  in  8  DCM STATUS bus, used only with the optional feature
DCM_RST_OUT  out  1  reset to the DCM RST pin
SYS_RST_OUT  out  1  reset to downstream logic
READY_OUT  out  1  clocks valid, system running
FAIL_OUT  out  1  sticky lock failure
RETRY_CNT_OUT  out  4  retries used in the current acquisition

Behaviour:
- Single clock, CLK_IN. Reset is synchronous and active-high on RST_IN. All outputs are registered and change on the same edge as the state register.
- On RST_IN=1:
  - state=RESET_DCM, counter=0, retry=0
  - DCM_RST_OUT=1, SYS_RST_OUT=1, READY_OUT=0, FAIL_OUT=0, RETRY_CNT_OUT=0
- LOCKED_IN passes through a 2-flop synchroniser to give lock_s (2-cycle latency). The synchroniser clears to 0 on RST_IN.
- One 16-bit counter is shared by all states and cleared on every state transition.
- RESET_DCM:
  - DCM_RST_OUT=1, SYS_RST_OUT=1.
  - Counts cycles; when count==RST_CYCLES-1, go to WAIT_LOCK. DCM_RST_OUT is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - DCM_RST_OUT=0, SYS_RST_OUT=1.
  - lock_s=1: go to STABLE.
  - Else, when count==LOCK_TIMEOUT-1:
    - retry==MAX_RETRY: go to FAIL.
    - Otherwise retry+=1 and go to RESET_DCM.
  - If lock_s=1 and the timeout occur in the same cycle, lock wins.
- STABLE:
  - DCM_RST_OUT=0, SYS_RST_OUT=1.
  - lock_s=0: go to WAIT_LOCK. The timeout restarts; retry is unchanged.
  - When count==STABLE_CYCLES-1 with lock_s=1: go to RUN.
- RUN:
  - SYS_RST_OUT=0, READY_OUT=1, retry cleared to 0 on entry.
  - lock_s=0: go to RESET_DCM. SYS_RST_OUT=1 and READY_OUT=0 take effect on that same edge.
- FAIL:
  - DCM_RST_OUT=1, SYS_RST_OUT=1, FAIL_OUT=1, READY_OUT=0.
  - Leaves only on RST_IN.
- RETRY_CNT_OUT = retry register at all times; it saturates at MAX_RETRY.
- RST_IN asserted mid-sequence, in any state: full return to the reset values on the next edge. No partial state is kept.
- LOCKED_IN glitch shorter than 1 cycle: may be missed; this is acceptable.

Optional Feature:
DCM_STATUS_MON_EN
- Defined:
  - In STABLE and RUN, STATUS_IN[1] (CLKIN stopped) or STATUS_IN[2] (CLKFX stopped), each passed through its own 2-flop synchroniser, is treated exactly like lock_s=0.
  - While in FAIL, STATUS_IN[1] is also ignored.
- Undefined:
  - STATUS_IN is unused; only LOCKED_IN is observed.

Test Plan:
Common parameters: RST_CYCLES=3, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRY=2.
1. Release RST_IN; LOCKED_IN rises 5 cycles after DCM_RST_OUT falls -> DCM_RST_OUT high exactly 3 cycles; SYS_RST_OUT falls and READY_OUT rises 2+8=10 cycles after LOCKED_IN rise; RETRY_CNT_OUT=0.
2. LOCKED_IN never asserts -> 3 DCM_RST_OUT pulses of 3 cycles each, separated by 16-cycle waits; RETRY_CNT_OUT goes 0,1,2; FAIL_OUT=1 on the final timeout, with DCM_RST_OUT=1 and SYS_RST_OUT=1 held; a later LOCKED_IN=1 has no effect until RST_IN.
3. LOCKED_IN high for 4 cycles then low in STABLE -> return to WAIT_LOCK, no retry increment, SYS_RST_OUT stays 1; relock for 8 cycles -> READY_OUT=1.
4. In RUN, drop LOCKED_IN for 1 cycle -> 2 cycles later SYS_RST_OUT=1, READY_OUT=0, DCM_RST_OUT=1 for 3 cycles, full reacquisition; RETRY_CNT_OUT restarts at 0.
5. Assert RST_IN for 1 cycle during WAIT_LOCK with retry=1 -> next edge returns all outputs and RETRY_CNT_OUT to reset values; the sequence restarts with a 3-cycle DCM pulse.
6. (DCM_STATUS_MON_EN) In RUN, set STATUS_IN=8'h04 with LOCKED_IN=1 -> SYS_RST_OUT=1 within 2 cycles and re-sequence; without the macro, no reaction.
